// File: rtl/sb_3320_path_director_if.sv
// Path-node input, turn-record output and neighbour-table write port of sb_3320_path_director.
interface sb_3320_path_director_if #(parameter int NODE_W = 5);
    logic              cfg_we;
    logic [NODE_W-1:0] cfg_node;
    logic [1:0]        cfg_port;
    logic [NODE_W-1:0] cfg_nbr;

    logic              in_valid;
    logic              in_ready;
    logic [NODE_W-1:0] in_node;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [NODE_W-1:0] out_node;
    logic [2:0]        out_dir;
    logic              out_err;
    logic              out_last;

    modport master (
        output cfg_we, cfg_node, cfg_port, cfg_nbr,
        output in_valid, in_node, in_last, out_ready,
        input  in_ready, out_valid, out_node, out_dir, out_err, out_last
    );

    modport slave (
        input  cfg_we, cfg_node, cfg_port, cfg_nbr,
        input  in_valid, in_node, in_last, out_ready,
        output in_ready, out_valid, out_node, out_dir, out_err, out_last
    );
endinterface

// File: rtl/sb_3320_path_director.sv
// Streaming path-to-turn translator using a run-time-writable neighbour table.
// Optional macro SB_3320_PATH_UTURN_EN: prev==nxt yields an extreme (U-turn) command instead of an error.
module sb_3320_path_director #(
    parameter int NODE_W   = 5,
    parameter int NODES    = 28,
    parameter int START_ID = 27
) (
    input  logic                    clk_50,
    input  logic                    reset,
    sb_3320_path_director_if.slave  bus,
    output logic                    busy
);
    localparam logic [NODE_W-1:0] NONE    = '1;
    localparam logic [NODE_W-1:0] ST_ID   = NODE_W'(START_ID);
    localparam logic [NODE_W-1:0] LAST_ID = NODE_W'(NODES - 1);

    typedef enum logic [2:0] {IDLE, FILL, SCAN, EMIT, STOP} state_t;
    state_t state, state_nx;

    logic [NODE_W-1:0] tbl [NODES][4];
    logic [NODE_W-1:0] cur, prev, nxt, ent;
    logic              last_l, pin_ok, pout_ok;
    logic [1:0]        k, pin, pout, rel;
    logic              in_rdy, acc;

    assign acc = bus.in_valid && in_rdy;
    assign ent = (cur <= LAST_ID) ? tbl[cur][k] : NONE;
    assign rel = pout - pin - 2'd2;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int n = 0; n < NODES; n++)
                for (int p = 0; p < 4; p++)
                    tbl[n][p] <= NONE;
        end else if (state == IDLE && bus.cfg_we && bus.cfg_node <= LAST_ID) begin
            tbl[bus.cfg_node][bus.cfg_port] <= bus.cfg_nbr;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (acc) state_nx = bus.in_last ? STOP : FILL;
            FILL: if (acc) state_nx = SCAN;
            SCAN: if (k == 2'd3) state_nx = EMIT;
            EMIT: if (bus.out_ready) state_nx = last_l ? STOP : FILL;
            STOP: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Out-of-range IDs never match, so an all-ones ID cannot alias a NONE entry.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            cur <= '0; prev <= ST_ID; nxt <= '0; last_l <= 1'b0;
            k <= '0; pin <= '0; pout <= '0; pin_ok <= 1'b0; pout_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    cur  <= bus.in_node;
                    prev <= ST_ID;
                end
                FILL: if (acc) begin
                    nxt     <= bus.in_node;
                    last_l  <= bus.in_last;
                    k       <= '0;
                    pin_ok  <= 1'b0;
                    pout_ok <= 1'b0;
                end
                SCAN: begin
                    k <= k + 2'd1;
                    if (!pin_ok && prev <= LAST_ID && ent == prev) begin
                        pin <= k; pin_ok <= 1'b1;
                    end
                    if (!pout_ok && nxt <= LAST_ID && ent == nxt) begin
                        pout <= k; pout_ok <= 1'b1;
                    end
                end
                EMIT: if (bus.out_ready) begin
                    prev <= cur;
                    cur  <= nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_rdy        = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_node  = '0;
        bus.out_dir   = 3'b000;
        bus.out_err   = 1'b0;
        bus.out_last  = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE, FILL: in_rdy = 1'b1;
            EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_node  = cur;
                if (!pout_ok || (prev != ST_ID && !pin_ok)) begin
                    bus.out_err = 1'b1;
                end else if (prev == ST_ID) begin
                    bus.out_dir = 3'b001;
                end else begin
                    case (rel)
                        2'd0: bus.out_dir = 3'b001;
                        2'd1: bus.out_dir = 3'b011;
                        2'd3: bus.out_dir = 3'b010;
`ifdef SB_3320_PATH_UTURN_EN
                        default: bus.out_dir = 3'b100;
`else
                        default: bus.out_err = 1'b1;
`endif
                    endcase
                end
            end
            STOP: begin
                bus.out_valid = 1'b1;
                bus.out_node  = cur;
                bus.out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.in_ready = in_rdy;
endmodule

// File: tb/tb_sb_3320_path_director.sv
// Directed bench for sb_3320_path_director: table setup, turn decoding, stalls, reset mid-scan.
module tb_sb_3320_path_director;
    logic clk_50 = 1'b0;
    logic reset;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    sb_3320_path_director_if #(.NODE_W(5)) bus ();

    sb_3320_path_director #(.NODE_W(5), .NODES(28), .START_ID(27)) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus.slave),
        .busy   (busy)
    );

    always #5 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [4:0] node, input logic [1:0] port, input logic [4:0] nbr);
        bus.cfg_we = 1'b1; bus.cfg_node = node; bus.cfg_port = port; bus.cfg_nbr = nbr;
        @(negedge clk_50);
        bus.cfg_we = 1'b0;
    endtask

    task automatic send(input logic [4:0] node, input logic last);
        int n = 0;
        bus.in_valid = 1'b1; bus.in_node = node; bus.in_last = last;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk_50);
            n++;
        end
        if (n >= 40) chk("send_timeout", 32'(n), 0);
        @(negedge clk_50);
        bus.in_valid = 1'b0;
    endtask

    // Record packed as {node, dir, err, last}; stall = cycles out_ready is held low.
    task automatic rec(input string tag, input logic [4:0] node, input logic [2:0] dir,
                       input logic err, input logic last, input int stall);
        int n = 0;
        logic [9:0] exp;
        exp = {node, dir, err, last};
        while (!bus.out_valid && n < 40) begin
            @(negedge clk_50);
            n++;
        end
        if (n >= 40) chk({tag, "_timeout"}, 32'(n), 0);
        chk(tag, 32'({bus.out_node, bus.out_dir, bus.out_err, bus.out_last}), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_50);
            chk({tag, "_hold"}, 32'({bus.out_valid, bus.out_node, bus.out_dir, bus.out_err, bus.out_last}),
                32'({1'b1, exp}));
            chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk_50);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_node = '0; bus.cfg_port = '0; bus.cfg_nbr = '0;
        bus.in_valid = 1'b0; bus.in_node = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk_50);
        reset = 1'b0;
        chk("reset_outs", 32'({bus.out_valid, bus.out_dir, bus.out_err, bus.out_last, bus.out_node}), 0);
        chk("reset_busy_ready", 32'({busy, bus.in_ready}), 32'b01);

        cfg(5'd5, 2'd0, 5'd2);
        cfg(5'd5, 2'd1, 5'd6);
        cfg(5'd5, 2'd2, 5'd9);
        cfg(5'd2, 2'd2, 5'd5);
        cfg(5'd6, 2'd3, 5'd5);
        cfg(5'd9, 2'd0, 5'd5);

        // 2,5,6: forward, left, stop; includes the latency check
        send(5'd2, 1'b0);
        chk("busy_fill", 32'(busy), 1);
        send(5'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("latency_scan", 32'({bus.out_valid, bus.in_ready}), 0);
            @(negedge clk_50);
        end
        chk("latency_t5", 32'(bus.out_valid), 1);
        rec("p256_r0", 5'd2, 3'b001, 1'b0, 1'b0, 0);
        send(5'd6, 1'b1);
        rec("p256_r1", 5'd5, 3'b010, 1'b0, 1'b0, 0);
        rec("p256_r2", 5'd6, 3'b000, 1'b0, 1'b1, 0);
        chk("idle_after", 32'({busy, bus.out_valid}), 0);

        // 9,5,2: forward, forward
        send(5'd9, 1'b0); send(5'd5, 1'b0);
        rec("p952_r0", 5'd9, 3'b001, 1'b0, 1'b0, 0);
        send(5'd2, 1'b1);
        rec("p952_r1", 5'd5, 3'b001, 1'b0, 1'b0, 0);
        rec("p952_r2", 5'd2, 3'b000, 1'b0, 1'b1, 0);

        // 6,5,2: middle is right
        send(5'd6, 1'b0); send(5'd5, 1'b0);
        rec("p652_r0", 5'd6, 3'b001, 1'b0, 1'b0, 0);
        send(5'd2, 1'b1);
        rec("p652_r1", 5'd5, 3'b011, 1'b0, 1'b0, 0);
        rec("p652_r2", 5'd2, 3'b000, 1'b0, 1'b1, 0);

        // 2,5,2: U-turn
        send(5'd2, 1'b0); send(5'd5, 1'b0);
        rec("p252_r0", 5'd2, 3'b001, 1'b0, 1'b0, 0);
        send(5'd2, 1'b1);
`ifdef SB_3320_PATH_UTURN_EN
        rec("p252_r1", 5'd5, 3'b100, 1'b0, 1'b0, 0);
`else
        rec("p252_r1", 5'd5, 3'b000, 1'b1, 1'b0, 0);
`endif
        rec("p252_r2", 5'd2, 3'b000, 1'b0, 1'b1, 0);

        // 2,6: non-adjacent
        send(5'd2, 1'b0); send(5'd6, 1'b1);
        rec("p26_r0", 5'd2, 3'b000, 1'b1, 1'b0, 0);
        rec("p26_r1", 5'd6, 3'b000, 1'b0, 1'b1, 0);

        // out-of-range next node
        send(5'd2, 1'b0); send(5'd30, 1'b1);
        rec("poor_r0", 5'd2, 3'b000, 1'b1, 1'b0, 0);
        rec("poor_r1", 5'd30, 3'b000, 1'b0, 1'b1, 0);

        // single-node path
        send(5'd7, 1'b1);
        rec("p7_r0", 5'd7, 3'b000, 1'b0, 1'b1, 0);

        // 2,5,6 with back-pressure on every record
        send(5'd2, 1'b0); send(5'd5, 1'b0);
        rec("stall_r0", 5'd2, 3'b001, 1'b0, 1'b0, 3);
        send(5'd6, 1'b1);
        rec("stall_r1", 5'd5, 3'b010, 1'b0, 1'b0, 3);
        rec("stall_r2", 5'd6, 3'b000, 1'b0, 1'b1, 3);

        // reset during SCAN clears the table and drops the record
        send(5'd2, 1'b0); send(5'd5, 1'b0);
        @(negedge clk_50);
        chk("pre_reset_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk_50);
        reset = 1'b0;
        chk("scan_reset", 32'({busy, bus.out_valid, bus.in_ready}), 32'b001);
        chk("scan_reset_outs", 32'({bus.out_dir, bus.out_err, bus.out_last, bus.out_node}), 0);
        send(5'd2, 1'b0); send(5'd5, 1'b1);
        rec("rerun_r0", 5'd2, 3'b000, 1'b1, 1'b0, 0);
        rec("rerun_r1", 5'd5, 3'b000, 1'b0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sb_3320_path_director.md
# sb_3320_path_director

Streaming path-to-turn translator for the bot's navigation datapath. Accepts a path as a sequence of node IDs, keeps a sliding (previous, current, next) window, and emits one turn command per node. It replaces a hard-coded triple-indexed map with a run-time-writable per-node neighbour table, and is parametrised in node count and ID width. The output drives the motion controller.

## Interface
- NODE_W, 5: node ID width.
- NODES, 28: table entries; valid IDs are 0..NODES-1.
- START_ID, 27: pseudo-node meaning "path entry from outside"; must differ from all-ones.
- clk_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe; honoured only in IDLE.
- cfg_node  in  NODE_W  node whose table row is written.
- cfg_port  in  2  port written: 0=N, 1=E, 2=S, 3=W (clockwise).
- cfg_nbr  in  NODE_W  neighbour ID on that port; all-ones (NONE) means no neighbour.
- in_valid / in_ready  in / out  1  path node handshake.
- in_node  in  NODE_W  path node.
- in_last  in  1  marks final node of path.
- out_valid / out_ready  out / in  1  turn handshake.
- out_node  out  NODE_W  node the turn applies to.
- out_dir  out  3  000 stop, 001 forward, 010 left, 011 right, 100 extreme (U-turn).
- out_err  out  1  lookup failed (non-adjacent nodes or illegal U-turn).
- out_last  out  1  final record of the path.
- busy  out  1  high in every state except IDLE.

## Operation
- Table: NODES x 4 entries of NODE_W bits. Reset writes NONE to all entries. A write in IDLE takes effect on the next cycle.
- States: IDLE, FILL, SCAN, EMIT, STOP.
- IDLE: in_ready=1. On accept: cur<=in_node, prev<=START_ID. If in_last, go to STOP; otherwise go to FILL.
- FILL: in_ready=1. On accept: nxt<=in_node, latch in_last, go to SCAN.
- SCAN: port counter k runs 0..3, one port per cycle. p_in is the lowest k with table[cur][k]==prev; p_out is the lowest k with table[cur][k]==nxt.
- Turn at end of SCAN: rel=(p_out-p_in-2) mod 4. Codes: 0 forward, 1 right, 3 left, 2 extreme.
- prev==START_ID: p_in is not needed; dir=forward if p_out is found.
- p_out not found, or p_in not found when prev!=START_ID: out_dir=000, out_err=1.
- EMIT: out_valid=1, out_node=cur. On out_ready: prev<=cur, cur<=nxt. Go to STOP if the latched last flag is set; otherwise go to FILL.
- STOP: emit out_node=cur, out_dir=000, out_last=1, out_err=0. On out_ready, go to IDLE.
- A path of N nodes yields exactly N output records.

## Timing
- Reset values: out_valid=0, out_dir=000, out_err=0, out_last=0, out_node=0, busy=0, in_ready=1 (IDLE).
- Latency: FILL accept at cycle t, SCAN t+1..t+4, out_valid asserted at t+5.
- out_* hold stable while out_valid=1 and out_ready=0.
- in_ready=0 in SCAN, EMIT and STOP, so at most one node is pending.
- Reset asserted in any state: next cycle is IDLE, outputs at reset values, table cleared, any in-flight record dropped.
- cfg_we outside IDLE is ignored. cfg_node>=NODES is ignored.
- in_node>=NODES is treated as non-adjacent and produces out_err=1.

## Configuration
- SB_3320_PATH_UTURN_EN defined: rel==2 (p_out==p_in, i.e. prev==nxt) yields out_dir=100 (extreme), out_err=0. This supports dead-end reversal.
- Not defined: rel==2 yields out_dir=000, out_err=1.

## Test plan
- Table: node5={N:2, E:6, S:9, W:NONE}, node2 S=5, node6 W=5. Stream 2,5,6(last) -> records (2,001), (5,010), (6,000,last); err=0 throughout.
- Same table. Stream 9,5,2(last) -> (9,001), (5,001), (2,000,last). Stream 6,5,2(last) -> middle record (5,011).
- Stream 2,5,2(last) -> middle record (5,100,err=0) with macro defined; (5,000,err=1) without macro.
- Stream 2,6(last), which are non-adjacent -> (2,000,err=1), then (6,000,last).
- Stream 2,5,6 with out_ready low for 3 cycles at each record -> out_* stable, in_ready=0 until the handshake completes, no records lost. Check t+5 latency.
- Assert reset during SCAN -> next cycle busy=0, out_valid=0, in_ready=1. Table reads NONE, so a rerun of 2,5 gives err=1.
